cayde_regfile_sb: RTL

Parametrised successor to the 32x32 integer register file, for the cayde core's decode/writeback boundary.
- Two combinational read ports and one synchronous write port; read width, depth and zero-register handling are parameterised.
- Optional write-to-read bypass.
- Per-register busy scoreboard: set on issue, cleared on writeback; drives the decode stall logic.
- Post-reset clear sequencer zeroes the array one entry per cycle, so the storage maps to RAM/LUTRAM without a reset net on every bit.

---
 rtl/cayde_regfile_sb.sv | 123 ++++++++++++
 1 files changed

// File: rtl/cayde_regfile_sb.sv
// Register file with two combinational read ports, one write port, optional write-to-read
// bypass and a per-register busy scoreboard; storage is zeroed by a post-reset clear sequencer.
module cayde_regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr_in1,
  input  logic [ADDR_W-1:0] raddr_in2,
  output logic [XLEN-1:0]   rdata_out1,
  output logic [XLEN-1:0]   rdata_out2,
  output logic              rbusy_out1,
  output logic              rbusy_out2,
  input  logic [ADDR_W-1:0] waddr_in,
  input  logic [XLEN-1:0]   wdata_in,
  input  logic              wen_in,
  input  logic              issue_en_in,
  input  logic [ADDR_W-1:0] issue_rd_in,
  output logic              ready_out
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  typedef enum logic {StClear, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   mem_q [NREGS];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [XLEN-1:0]   mem_wd;
  logic              run;

  assign run       = (state_q == StRun);
  assign ready_out = run;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StClear) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == {ADDR_W{1'b1}}) begin
        state_d = StRun;
      end
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (wen_in) begin
        busy_d[waddr_in] = 1'b0;
      end
      if (issue_en_in) begin
        busy_d[issue_rd_in] = 1'b1;
      end
      if (ZERO_REG) begin
        busy_d[0] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Single write port shared by the clear sequencer and writeback; no reset on the array.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = waddr_in;
    mem_wd = wdata_in;
    if (state_q == StClear) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = '0;
    end else if (wen_in && !(ZERO_REG && (waddr_in == '0))) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  logic [1:0][ADDR_W-1:0] raddr;
  logic [1:0][XLEN-1:0]   rdata;
  logic [1:0]             rbusy;

  assign raddr[0] = raddr_in1;
  assign raddr[1] = raddr_in2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic zero_hit;
    logic fwd_hit;

    assign zero_hit = ZERO_REG && (raddr[p] == '0);
    assign fwd_hit  = BYPASS && wen_in && (waddr_in == raddr[p]);
    assign rdata[p] = (!run || zero_hit) ? '0   : (fwd_hit ? wdata_in : mem_q[raddr[p]]);
    assign rbusy[p] = (!run || zero_hit) ? 1'b0 : (fwd_hit ? 1'b0     : busy_q[raddr[p]]);
  end

  assign rdata_out1 = rdata[0];
  assign rdata_out2 = rdata[1];
  assign rbusy_out1 = rbusy[0];
  assign rbusy_out2 = rbusy[1];

endmodule
